// File: rtl/dcu.sv
// Decode/control unit: routes the granted master's AXI transaction to a slave.
// Optional DCU_DECERR_EN macro enables an internal DECERR default slave.
module dcu #(
    parameter int          ADDR_W = 32,
    parameter logic [3:0]  S0_TAG = 4'h0,
    parameter logic [3:0]  S1_TAG = 4'h1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mas_sel,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    input  logic              wready,
    input  logic              wlast,
    input  logic              bvalid,
    input  logic              bready,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    output logic [1:0]        slv_sel,
    output logic              endtrans,
    output logic              dflt_awready,
    output logic              dflt_wready,
    output logic              dflt_bvalid,
    output logic [1:0]        dflt_bresp,
    output logic              dflt_arready,
    output logic              dflt_rvalid,
    output logic              dflt_rlast,
    output logic [1:0]        dflt_rresp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_S0   = 2'b01;
    localparam logic [1:0] SEL_S1   = 2'b10;
    localparam logic [1:0] SEL_DFLT = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;

    logic       granted;
    logic [3:0] aw_tag, ar_tag;
    logic [1:0] aw_dec, ar_dec, req_dec;
    logic       aw_hs, ar_hs, w_last_hs, b_hs, r_hs, r_last_hs;

    function automatic logic [1:0] decode(input logic [3:0] tag);
        logic [1:0] res;
        if (tag == S0_TAG) begin
            res = SEL_S0;
        end else if (tag == S1_TAG) begin
            res = SEL_S1;
        end else begin
`ifdef DCU_DECERR_EN
            res = SEL_DFLT;
`else
            res = SEL_S0;
`endif
        end
        return res;
    endfunction

    assign granted   = (mas_sel != 2'b00);
    assign aw_tag    = awaddr[ADDR_W-1 -: 4];
    assign ar_tag    = araddr[ADDR_W-1 -: 4];
    assign aw_dec    = decode(aw_tag);
    assign ar_dec    = decode(ar_tag);
    assign req_dec   = awvalid ? aw_dec : (arvalid ? ar_dec : SEL_NONE);
    assign aw_hs     = awvalid & awready;
    assign ar_hs     = arvalid & arready & ~awvalid;
    assign w_last_hs = wvalid & wready & wlast;
    assign b_hs      = bvalid & bready;
    assign r_hs      = rvalid & rready;
    assign r_last_hs = r_hs & rlast;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[ADDR_W-5:0], araddr[ADDR_W-5:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        slv_sel  = SEL_NONE;
        endtrans = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (granted) begin
                    slv_sel = req_dec;
                    // A pending write always wins over a simultaneous read.
                    if (aw_hs) begin
                        state_d = WDATA;
                        sel_d   = aw_dec;
                    end else if (ar_hs) begin
                        state_d = RDATA;
                        sel_d   = ar_dec;
                    end
                end
            end
            WDATA: begin
                slv_sel = sel_q;
                if (w_last_hs) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                slv_sel = sel_q;
                if (b_hs) begin
                    state_d = DONE;
                end
            end
            RDATA: begin
                slv_sel = sel_q;
                if (r_last_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                endtrans = 1'b1;
                state_d  = IDLE;
                sel_d    = SEL_NONE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_NONE;
            end
        endcase
        if (!rstn) begin
            slv_sel  = SEL_NONE;
            endtrans = 1'b0;
        end
    end

`ifdef DCU_DECERR_EN
    logic [7:0] cnt_q, cnt_d;
    logic       dflt_sel;

    assign dflt_sel = (sel_q == SEL_DFLT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && granted && ar_hs) begin
            cnt_d = arlen;
        end else if (state_q == RDATA && r_hs && cnt_q != 8'd0) begin
            // Saturates at zero so the last beat never wraps the count.
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_comb begin
        dflt_awready = 1'b0;
        dflt_arready = 1'b0;
        dflt_wready  = 1'b0;
        dflt_bvalid  = 1'b0;
        dflt_rvalid  = 1'b0;
        dflt_rlast   = 1'b0;
        dflt_bresp   = 2'b11;
        dflt_rresp   = 2'b11;
        if (state_q == IDLE && granted) begin
            dflt_awready = awvalid & (aw_dec == SEL_DFLT);
            dflt_arready = ~awvalid & arvalid & (ar_dec == SEL_DFLT);
        end
        dflt_wready = (state_q == WDATA) & dflt_sel;
        dflt_bvalid = (state_q == WRESP) & dflt_sel;
        dflt_rvalid = (state_q == RDATA) & dflt_sel;
        dflt_rlast  = dflt_rvalid & (cnt_q == 8'd0);
        if (!rstn) begin
            dflt_awready = 1'b0;
            dflt_arready = 1'b0;
            dflt_wready  = 1'b0;
            dflt_bvalid  = 1'b0;
            dflt_rvalid  = 1'b0;
            dflt_rlast   = 1'b0;
            dflt_bresp   = 2'b00;
            dflt_rresp   = 2'b00;
        end
    end
`else
    logic unused_rd;
    assign unused_rd    = ^arlen;
    assign dflt_awready = 1'b0;
    assign dflt_wready  = 1'b0;
    assign dflt_bvalid  = 1'b0;
    assign dflt_bresp   = 2'b00;
    assign dflt_arready = 1'b0;
    assign dflt_rvalid  = 1'b0;
    assign dflt_rlast   = 1'b0;
    assign dflt_rresp   = 2'b00;
`endif

endmodule

// File: tb/tb_dcu.sv
// Self-checking bench for dcu: decode vector table, scoreboarded
// transactions, reset abort and no-grant corner cases.
module tb_dcu;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  mas_sel;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [7:0]  arlen;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [1:0]  slv_sel;
    logic        endtrans;
    logic        dflt_awready, dflt_wready, dflt_bvalid, dflt_arready;
    logic        dflt_rvalid, dflt_rlast;
    logic [1:0]  dflt_bresp, dflt_rresp;

    dcu #(.ADDR_W(32), .S0_TAG(4'h0), .S1_TAG(4'h1)) dut (
        .clk(clk), .rstn(rstn), .mas_sel(mas_sel),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .slv_sel(slv_sel), .endtrans(endtrans),
        .dflt_awready(dflt_awready), .dflt_wready(dflt_wready),
        .dflt_bvalid(dflt_bvalid), .dflt_bresp(dflt_bresp),
        .dflt_arready(dflt_arready), .dflt_rvalid(dflt_rvalid),
        .dflt_rlast(dflt_rlast), .dflt_rresp(dflt_rresp)
    );

    always #5 clk = ~clk;

`ifdef DCU_DECERR_EN
    localparam logic [1:0] UNM = 2'b11;
    localparam logic       DE  = 1'b1;
`else
    localparam logic [1:0] UNM = 2'b01;
    localparam logic       DE  = 1'b0;
`endif

    int n_pass = 0;
    int n_tot  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] last_sel = 2'b00;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Scoreboard: each endtrans pulse retires the oldest expected routing.
    always @(negedge clk) begin
        if (rstn === 1'b1 && endtrans === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_endtrans", 1, 0);
            else chk("sb_sel", {30'd0, last_sel}, {30'd0, exp_q.pop_front()});
        end
        last_sel = slv_sel;
    end

    typedef struct {
        logic [1:0]  ms;
        logic        aw;
        logic [31:0] awa;
        logic        ar;
        logic [31:0] ara;
        logic [1:0]  exp_sel;
        logic        exp_daw;
        logic        exp_dar;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mas_sel = 2'b00;
        awvalid = 0; awready = 0; awaddr = 32'h0;
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; araddr = 32'h0; arlen = 8'd0;
        rvalid = 0; rready = 0; rlast = 0;
    endtask

    task automatic expect_done(string tag);
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 0; bready = 0;
        rvalid = 0; rready = 0; rlast = 0;
        @(negedge clk);
        chk({tag, "_endtrans"}, endtrans, 1);
        chk({tag, "_done_sel"}, slv_sel, 0);
        step();
        @(negedge clk);
        chk({tag, "_endtrans_low"}, endtrans, 0);
    endtask

    task automatic do_write(logic [1:0] ms, logic [31:0] a, int beats,
                            logic [1:0] es, string tag);
        mas_sel = ms; awvalid = 1; awaddr = a; awready = 1;
        @(negedge clk);
        chk({tag, "_aw_sel"}, slv_sel, es);
        exp_q.push_back(es);
        step();
        awvalid = 0; awready = 0; awaddr = 32'hFFFF_FFFF; mas_sel = 2'b00;
        for (int i = 0; i < beats; i++) begin
            wvalid = 1; wready = 1; wlast = (i == beats - 1);
            @(negedge clk);
            chk({tag, "_w_sel"}, slv_sel, es);
            chk({tag, "_w_endtrans"}, endtrans, 0);
            step();
        end
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 1; bready = 1;
        @(negedge clk);
        chk({tag, "_b_sel"}, slv_sel, es);
        step();
        expect_done(tag);
    endtask

    task automatic do_read(logic [1:0] ms, logic [31:0] a, logic [7:0] len,
                           logic [1:0] es, string tag);
        mas_sel = ms; arvalid = 1; araddr = a; arlen = len; arready = 1;
        @(negedge clk);
        chk({tag, "_ar_sel"}, slv_sel, es);
        exp_q.push_back(es);
        step();
        arvalid = 0; arready = 0; araddr = 32'hFFFF_FFFF; mas_sel = 2'b00;
        rready = 1;
        @(negedge clk);
        chk({tag, "_stall_sel"}, slv_sel, es);
        step();
        for (int i = 0; i <= int'(len); i++) begin
            rvalid = 1; rready = 1; rlast = (i == int'(len));
            @(negedge clk);
            chk({tag, "_r_sel"}, slv_sel, es);
            chk({tag, "_r_endtrans"}, endtrans, 0);
            step();
        end
        expect_done(tag);
    endtask

    initial begin
        int seen;
        clear_in();
        rstn = 0;
        mas_sel = 2'b01; awvalid = 1; awaddr = 32'h1000_0000;
        arvalid = 1; araddr = 32'h2000_0000;
        @(negedge clk);
        chk("rst_sel", slv_sel, 0);
        chk("rst_endtrans", endtrans, 0);
        chk("rst_dflt", {dflt_awready, dflt_arready, dflt_wready,
                         dflt_bvalid, dflt_rvalid, dflt_rlast}, 0);
        clear_in();
        @(posedge clk);
        #1 rstn = 1;

        vecs[0] = '{2'b01, 1, 32'h0000_0010, 0, 32'h0, 2'b01, 0, 0};
        vecs[1] = '{2'b10, 1, 32'h1FFF_FFFF, 0, 32'h0, 2'b10, 0, 0};
        vecs[2] = '{2'b01, 0, 32'h0, 1, 32'h1000_0000, 2'b10, 0, 0};
        vecs[3] = '{2'b01, 0, 32'h1000_0000, 0, 32'h1000_0000, 2'b00, 0, 0};
        vecs[4] = '{2'b00, 1, 32'h1000_0000, 1, 32'h1000_0000, 2'b00, 0, 0};
        vecs[5] = '{2'b01, 1, 32'h0000_0004, 1, 32'h1000_0000, 2'b01, 0, 0};
        vecs[6] = '{2'b10, 1, 32'h2000_0000, 0, 32'h0, UNM, DE, 0};
        vecs[7] = '{2'b01, 0, 32'h0, 1, 32'hF000_0000, UNM, 0, DE};
        for (int i = 0; i < 8; i++) begin
            mas_sel = vecs[i].ms;
            awvalid = vecs[i].aw; awaddr = vecs[i].awa;
            arvalid = vecs[i].ar; araddr = vecs[i].ara;
            @(negedge clk);
            chk($sformatf("vec%0d_sel", i), slv_sel, vecs[i].exp_sel);
            chk($sformatf("vec%0d_endtrans", i), endtrans, 0);
            chk($sformatf("vec%0d_daw", i), dflt_awready, vecs[i].exp_daw);
            chk($sformatf("vec%0d_dar", i), dflt_arready, vecs[i].exp_dar);
        end
        clear_in();
        step();

        do_write(2'b01, 32'h0000_0010, 4, 2'b01, "wr_s0");
        do_read(2'b10, 32'h1000_0000, 8'd3, 2'b10, "rd_s1");

        arvalid = 1; araddr = 32'h1000_0000; arready = 1; arlen = 8'd0;
        do_write(2'b01, 32'h0000_0040, 1, 2'b01, "both");
        clear_in();
        step();

`ifdef DCU_DECERR_EN
        mas_sel = 2'b01; awvalid = 1; awaddr = 32'h2000_0000;
        @(negedge clk);
        chk("de_awready", dflt_awready, 1);
        chk("de_aw_sel", slv_sel, 2'b11);
        awready = 1;
        exp_q.push_back(2'b11);
        step();
        clear_in();
        for (int i = 0; i < 2; i++) begin
            wvalid = 1; wlast = (i == 1);
            @(negedge clk);
            chk("de_wready", dflt_wready, 1);
            wready = 1;
            step();
        end
        wvalid = 0; wready = 0; wlast = 0;
        @(negedge clk);
        chk("de_bvalid", dflt_bvalid, 1);
        chk("de_bresp", dflt_bresp, 2'b11);
        bvalid = 1; bready = 1;
        step();
        expect_done("de_wr");

        mas_sel = 2'b01; arvalid = 1; araddr = 32'h3000_0000; arlen = 8'd2;
        @(negedge clk);
        chk("de_arready", dflt_arready, 1);
        arready = 1;
        exp_q.push_back(2'b11);
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            rready = 1;
            @(negedge clk);
            chk("de_rvalid", dflt_rvalid, 1);
            chk("de_rlast", dflt_rlast, (i == 2));
            chk("de_rresp", dflt_rresp, 2'b11);
            rvalid = 1; rlast = (i == 2);
            step();
        end
        expect_done("de_rd");
`else
        do_write(2'b01, 32'h2000_0000, 2, UNM, "wr_unm");
        chk("unm_dflt_bvalid", dflt_bvalid, 0);
`endif

        mas_sel = 2'b01; arvalid = 1; araddr = 32'h0000_0100;
        arlen = 8'd3; arready = 1;
        exp_q.push_back(2'b01);
        step();
        arvalid = 0; arready = 0; mas_sel = 2'b00;
        rvalid = 1; rready = 1; rlast = 0;
        step();
        #2 rstn = 0;
        #1;
        chk("abort_sel", slv_sel, 0);
        chk("abort_endtrans", endtrans, 0);
        clear_in();
        step();
        rstn = 1;
        void'(exp_q.pop_back());
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (endtrans === 1'b1) seen++;
        end
        chk("abort_no_endtrans", seen, 0);
        mas_sel = 2'b01; awvalid = 1; awaddr = 32'h1000_0000;
        @(negedge clk);
        chk("abort_idle_sel", slv_sel, 2'b10);

        mas_sel = 2'b00; awvalid = 1; awready = 1; awaddr = 32'h1000_0000;
        @(negedge clk);
        chk("nogrant_sel", slv_sel, 0);
        chk("nogrant_endtrans", endtrans, 0);
        step();
        mas_sel = 2'b01; awready = 0;
        @(negedge clk);
        chk("nogrant_still_idle", slv_sel, 2'b10);
        clear_in();
        step();
        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
